// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_chain
// Description : Control-word pipeline for the processor controller. Carries
//               a W-bit decoded control word through STAGES registered
//               stages (stage 0 = execute ... STAGES-1 = writeback). Each
//               stage has its own stall, flush and valid bit, plus a field
//               mask. Bubbles are inserted automatically behind a stalled
//               stage, stalls can optionally propagate upstream, and a
//               counter tracks the instructions retired from the last stage.
//
// Ports       : clk         - clock, rising edge
//               rst         - synchronous reset, active-high
//               in_data     - decoded control word entering stage 0
//               in_valid    - in_data is a real instruction
//               stall       - per-stage stall request (bit s = stage s)
//               flush       - per-stage flush request
//               stage_data  - registered word per stage, [s*W +: W]
//               stage_valid - registered valid bit per stage
//               stall_eff   - effective stall after propagation (comb)
//               empty       - no stage holds a valid word (comb)
//               retire_cnt  - retired-instruction counter, wraps
//
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_chain #(
  parameter int                  W          = 19,
  parameter int                  STAGES     = 3,
  parameter logic [STAGES*W-1:0] KEEP_MASK  = {STAGES*W{1'b1}},
  parameter bit                  PROP_STALL = 1'b1,
  parameter int                  CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  input  logic [STAGES-1:0]   stall,
  input  logic [STAGES-1:0]   flush,
  output logic [STAGES*W-1:0] stage_data,
  output logic [STAGES-1:0]   stage_valid,
  output logic [STAGES-1:0]   stall_eff,
  output logic                empty,
  output logic [CNT_W-1:0]    retire_cnt
);

  logic [STAGES-1:0] w_stall_eff;
  logic              w_retire;
  logic [CNT_W-1:0]  r_retire_cnt;

  // Walk from the last stage back toward stage 0 so a downstream stall
  // ripples upstream when propagation is enabled.
  always_comb begin
    w_stall_eff = stall;
    for (int s = STAGES - 2; s >= 0; s--) begin
      w_stall_eff[s] = stall[s] | (PROP_STALL & w_stall_eff[s+1]);
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [W-1:0] w_src_data;
    logic         w_src_valid;
    logic         w_bubble;
    logic [W-1:0] r_data;
    logic         r_valid;

    if (s == 0) begin : g_head
      assign w_src_data  = in_data;
      assign w_src_valid = in_valid;
      assign w_bubble    = 1'b0;
    end else begin : g_body
      assign w_src_data  = stage_data[(s-1)*W +: W];
      assign w_src_valid = stage_valid[s-1];
      // Upstream is holding its word; taking it here would duplicate it.
      assign w_bubble    = w_stall_eff[s-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (flush[s]) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (!w_stall_eff[s]) begin
        if (w_bubble) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          // Invalid slots are forced to zero so no enable leaks downstream.
          r_valid <= w_src_valid;
          r_data  <= w_src_valid ? (w_src_data & KEEP_MASK[s*W +: W]) : '0;
        end
      end
    end

    assign stage_data[s*W +: W] = r_data;
    assign stage_valid[s]       = r_valid;
  end

  assign w_retire = stage_valid[STAGES-1] & ~w_stall_eff[STAGES-1] &
                    ~flush[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign stall_eff  = w_stall_eff;
  assign empty      = ~|stage_valid;
  assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe_chain
// Description : Self-checking bench for ctrl_pipe_chain. Two instances share
//               the same stimulus: A uses default parameters, B uses no stall
//               propagation, a narrow stage-2 field mask and a 4-bit retire
//               counter. A behavioural model tracks both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_chain;
  localparam int W      = 19;
  localparam int STAGES = 3;
  localparam logic [STAGES*W-1:0] MASK_B = {19'h0000F, {(2*W){1'b1}}};

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [W-1:0]        in_data;
  logic [STAGES-1:0]   stall;
  logic [STAGES-1:0]   flush;

  logic [STAGES*W-1:0] data_a, data_b;
  logic [STAGES-1:0]   valid_a, valid_b, seff_a, seff_b;
  logic                empty_a, empty_b;
  logic [31:0]         cnt_a;
  logic [3:0]          cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_pipe_chain u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush), .stage_data(data_a), .stage_valid(valid_a),
    .stall_eff(seff_a), .empty(empty_a), .retire_cnt(cnt_a)
  );

  ctrl_pipe_chain #(
    .W(W), .STAGES(STAGES), .KEEP_MASK(MASK_B), .PROP_STALL(1'b0), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush), .stage_data(data_b), .stage_valid(valid_b),
    .stall_eff(seff_b), .empty(empty_b), .retire_cnt(cnt_b)
  );

  // ---------------- reference model (k=0 -> A, k=1 -> B) ----------------
  logic [W-1:0]    md   [2][STAGES];
  logic            mv   [2][STAGES];
  longint unsigned mc   [2];
  logic [W-1:0]    mmask[2][STAGES];
  int              mprop[2];
  longint unsigned mmod [2];

  // A stage is stalled by its own request, or by any request further
  // downstream when propagation is enabled.
  function automatic logic [STAGES-1:0] exp_seff(int k, logic [STAGES-1:0] st);
    logic [STAGES-1:0] e;
    for (int s = 0; s < STAGES; s++) begin
      e[s] = 1'b0;
      for (int j = s; j < STAGES; j++)
        if (st[j] && (j == s || mprop[k] != 0)) e[s] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [STAGES*W-1:0] exp_data(int k);
    logic [STAGES*W-1:0] v;
    for (int s = 0; s < STAGES; s++) v[s*W +: W] = md[k][s];
    return v;
  endfunction

  function automatic logic [STAGES-1:0] exp_valid(int k);
    logic [STAGES-1:0] v;
    for (int s = 0; s < STAGES; s++) v[s] = mv[k][s];
    return v;
  endfunction

  task automatic model_edge(int k);
    logic [STAGES-1:0] e;
    logic [W-1:0]      nd [STAGES];
    logic              nv [STAGES];
    logic              sv;
    logic [W-1:0]      sd;
    e = exp_seff(k, stall);
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin md[k][s] = '0; mv[k][s] = 1'b0; end
      mc[k] = 0;
    end else begin
      if (mv[k][STAGES-1] && !e[STAGES-1] && !flush[STAGES-1])
        mc[k] = (mc[k] + 1) % mmod[k];
      for (int s = 0; s < STAGES; s++) begin
        sv = (s == 0) ? in_valid : mv[k][s-1];
        sd = (s == 0) ? in_data  : md[k][s-1];
        if (flush[s])                begin nd[s] = '0; nv[s] = 1'b0; end
        else if (e[s])               begin nd[s] = md[k][s]; nv[s] = mv[k][s]; end
        else if (s > 0 && e[s-1])    begin nd[s] = '0; nv[s] = 1'b0; end
        else begin nv[s] = sv; nd[s] = sv ? (sd & mmask[k][s]) : '0; end
      end
      for (int s = 0; s < STAGES; s++) begin md[k][s] = nd[s]; mv[k][s] = nv[s]; end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(logic r, logic iv, logic [W-1:0] d,
                       logic [STAGES-1:0] st, logic [STAGES-1:0] fl);
    rst = r; in_valid = iv; in_data = d; stall = st; flush = fl;
    #2;
    chk("stall_eff_a", 64'(seff_a), 64'(exp_seff(0, st)));
    chk("stall_eff_b", 64'(seff_b), 64'(exp_seff(1, st)));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("data_a",  64'(data_a),  64'(exp_data(0)));
    chk("valid_a", 64'(valid_a), 64'(exp_valid(0)));
    chk("empty_a", 64'(empty_a), 64'(exp_valid(0) == '0));
    chk("cnt_a",   64'(cnt_a),   mc[0]);
    chk("data_b",  64'(data_b),  64'(exp_data(1)));
    chk("valid_b", 64'(valid_b), 64'(exp_valid(1)));
    chk("empty_b", 64'(empty_b), 64'(exp_valid(1) == '0));
    chk("cnt_b",   64'(cnt_b),   mc[1]);
  endtask

  initial begin
    logic [31:0]       c0;
    logic [STAGES-1:0] rs, rf;
    mprop[0] = 1; mprop[1] = 0;
    mmod[0]  = 64'd1 << 32; mmod[1] = 64'd16;
    for (int s = 0; s < STAGES; s++) begin
      mmask[0][s] = '1;
      mmask[1][s] = MASK_B[s*W +: W];
      md[0][s] = 'x; md[1][s] = 'x; mv[0][s] = 1'bx; mv[1][s] = 1'bx;
    end
    mc[0] = 0; mc[1] = 0;

    // Reset with a valid word present, then idle.
    cycle(1'b1, 1'b1, 19'h7FFFF, 3'b000, 3'b000);
    cycle(1'b1, 1'b1, 19'h7FFFF, 3'b000, 3'b000);
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    chk("rst_empty", 64'(empty_a), 64'd1);
    repeat (3) cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("idle_empty", 64'(empty_a & empty_b), 64'd1);

    // Streaming 1,2,3: latency and retire count.
    cycle(1'b0, 1'b1, 19'd1, 3'b000, 3'b000);
    chk("w1_s0", 64'(data_a[0 +: W]), 64'd1);
    cycle(1'b0, 1'b1, 19'd2, 3'b000, 3'b000);
    chk("w1_s1", 64'(data_a[W +: W]), 64'd1);
    cycle(1'b0, 1'b1, 19'd3, 3'b000, 3'b000);
    chk("w1_s2", 64'(data_a[2*W +: W]), 64'd1);
    cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("stream_cnt2", 64'(cnt_a), 64'd2);
    cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("stream_cnt3", 64'(cnt_a), 64'd3);

    // Stage-0 stall: stage 0 holds, stage 1 gets bubbles.
    cycle(1'b0, 1'b1, 19'h0000A, 3'b000, 3'b000);
    repeat (2) begin
      cycle(1'b0, 1'b0, 19'h0, 3'b001, 3'b000);
      chk("stl_hold_b", 64'(data_b[0 +: W]), 64'h0000A);
      chk("stl_bub_b", 64'({valid_b[1], data_b[W +: W]}), 64'd0);
    end
    cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("stl_release_b", 64'(data_b[W +: W]), 64'h0000A);
    repeat (2) cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);

    // Last-stage stall propagates upstream in A.
    cycle(1'b0, 1'b1, 19'h00011, 3'b000, 3'b000);
    cycle(1'b0, 1'b1, 19'h00022, 3'b000, 3'b000);
    cycle(1'b0, 1'b1, 19'h00033, 3'b000, 3'b000);
    c0 = cnt_a;
    cycle(1'b0, 1'b0, 19'h0, 3'b100, 3'b000);
    chk("prop_hold_cnt", 64'(cnt_a), 64'(c0));
    chk("prop_hold_s2", 64'(data_a[2*W +: W]), 64'h00011);
    cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("prop_retire", 64'(cnt_a), 64'(c0 + 32'd1));

    // Flush beats stall on stage 1; its word never retires.
    cycle(1'b0, 1'b0, 19'h0, 3'b010, 3'b010);
    chk("flush_s1", 64'({valid_a[1], data_a[W +: W]}), 64'd0);
    repeat (3) cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("flush_cnt", 64'(cnt_a), 64'(c0 + 32'd2));

    // Field mask on stage 2 of B and 4-bit counter wrap.
    cycle(1'b1, 1'b0, 19'h0, 3'b000, 3'b000);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, 19'h7FFFF, 3'b000, 3'b000);
      if (i == 2) begin
        chk("mask_b_s2", 64'(data_b[2*W +: W]), 64'h0000F);
        chk("mask_a_s2", 64'(data_a[2*W +: W]), 64'h7FFFF);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 19'h0, 3'b000, 3'b000);
    chk("wrap_cnt_b", 64'(cnt_b), 64'd1);
    chk("wrap_cnt_a", 64'(cnt_a), 64'd17);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      rf = ($urandom_range(0, 6) == 0) ? 3'($urandom) : 3'b000;
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 19'($urandom), rs, rf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
